// File: rtl/div_unit_seq_pkg.sv
// Shared encodings and constants for the sequential RV32M divider.
// Imported by the divider top and its testbench.
package div_unit_seq_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PREP = 2'b01,
        ITER = 2'b10,
        DONE = 2'b11
    } div_state_e;

    localparam logic [5:0]  ITER_LAST  = 6'd31;
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    // Bit 0 of the op encoding selects the unsigned variant.
    function automatic logic is_signed_op(input div_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/div_unit_seq_cla.sv
// 32-bit carry-lookahead adder/subtractor: 4-bit lookahead groups joined by a
// group-level generate/propagate chain. With sub=1, sum = a - b and c_out = no borrow.
module cla_adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] sum,
    output logic        c_out
);

    logic [31:0] bx;
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] cy;
    logic [7:0]  gg;
    logic [7:0]  gp;
    logic [8:0]  gc;

    assign bx = b ^ {32{sub}};
    assign g  = a & bx;
    assign p  = a ^ bx;

    // NOTE: every variable written in this combinational block is assigned on
    // every pass; a path that skips an assignment would infer a latch.
    always_comb begin
        gg = '0;
        gp = '0;
        gc = '0;
        cy = '0;
        for (int k = 0; k < 8; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
        end
        gc[0] = sub;
        for (int k = 0; k < 8; k++) begin
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        for (int k = 0; k < 8; k++) begin
            cy[4*k]   = gc[k];
            cy[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            cy[4*k+2] = g[4*k+1]
                      | (p[4*k+1] & g[4*k])
                      | (p[4*k+1] & p[4*k] & gc[k]);
            cy[4*k+3] = g[4*k+2]
                      | (p[4*k+2] & g[4*k+1])
                      | (p[4*k+2] & p[4*k+1] & g[4*k])
                      | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
    end

    assign sum   = p ^ cy;
    assign c_out = gc[8];

endmodule

// File: rtl/div_unit_seq.sv
// Sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One trial subtraction per cycle on a shared CLA; 32 iterations per operation.
module div_unit_seq
    import div_unit_seq_pkg::*;
#(
    parameter bit SPECIAL_FAST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    div_state_e  state_q,    state_d;
    div_op_e     op_q,       op_d;
    logic [31:0] dvd_q,      dvd_d;
    logic [31:0] dvs_q,      dvs_d;
    logic [31:0] rem_q,      rem_d;
    logic [31:0] quo_q,      quo_d;
    logic [5:0]  cnt_q,      cnt_d;
    logic        qneg_q,     qneg_d;
    logic        rneg_q,     rneg_d;
    logic        spec_q,     spec_d;
    logic [31:0] spec_res_q, spec_res_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic [31:0] result_q,   result_d;

    logic        signed_op;
    logic [31:0] dvd_abs;
    logic [31:0] dvs_abs;
    logic        div_zero;
    logic        sgn_ovf;
    logic [31:0] spec_res_now;

    logic [31:0] add_a;
    logic [31:0] add_diff;
    logic        add_nb;
    logic        trial_ok;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;
    logic [31:0] final_res;

    // Operand conditioning, evaluated while in PREP on the captured operands.
    assign signed_op = is_signed_op(op_q);
    assign dvd_abs   = (signed_op && dvd_q[31]) ? neg32(dvd_q) : dvd_q;
    assign dvs_abs   = (signed_op && dvs_q[31]) ? neg32(dvs_q) : dvs_q;
    assign div_zero  = (dvs_q == 32'd0);
    assign sgn_ovf   = signed_op && (dvd_q == INT_MIN) && (dvs_q == 32'hFFFF_FFFF);

    always_comb begin
        spec_res_now = '0;
        if (div_zero) begin
            spec_res_now = op_q[1] ? dvd_q : DIV_ZERO_Q;
        end else if (sgn_ovf) begin
            spec_res_now = op_q[1] ? 32'd0 : INT_MIN;
        end
    end

    // Trial subtraction of the shifted partial remainder {R, Q[31]}; the bit
    // shifted out of R guarantees success even when the adder reports a borrow.
    assign add_a = {rem_q[30:0], quo_q[31]};

    cla_adder_32 u_cla (
        .a    (add_a),
        .b    (dvs_q),
        .sub  (1'b1),
        .sum  (add_diff),
        .c_out(add_nb)
    );

    assign trial_ok  = rem_q[31] | add_nb;
    assign rem_nxt   = trial_ok ? add_diff : add_a;
    assign quo_nxt   = {quo_q[30:0], trial_ok};
    assign final_res = op_q[1] ? (rneg_q ? neg32(rem_nxt) : rem_nxt)
                               : (qneg_q ? neg32(quo_nxt) : quo_nxt);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        result_d   = result_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = PREP;
                    op_d    = div_op_e'(op);
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                end
            end
            PREP: begin
                qneg_d     = signed_op & (dvd_q[31] ^ dvs_q[31]);
                rneg_d     = signed_op & dvd_q[31];
                spec_d     = div_zero | sgn_ovf;
                spec_res_d = spec_res_now;
                dvs_d      = dvs_abs;
                quo_d      = dvd_abs;
                rem_d      = '0;
                cnt_d      = '0;
                if (SPECIAL_FAST && (div_zero || sgn_ovf)) begin
                    result_d = spec_res_now;
                    state_d  = DONE;
                end else begin
                    state_d  = ITER;
                end
            end
            ITER: begin
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == ITER_LAST) begin
                    result_d = spec_q ? spec_res_q : final_res;
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == PREP) || (state_d == ITER);
        done_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // NOTE: datapath registers carry no reset; their contents are only consumed
    // after PREP has reloaded them, so a reset term would only add muxing.
    always_ff @(posedge clk) begin
        op_q       <= op_d;
        dvd_q      <= dvd_d;
        dvs_q      <= dvs_d;
        rem_q      <= rem_d;
        quo_q      <= quo_d;
        qneg_q     <= qneg_d;
        rneg_q     <= rneg_d;
        spec_q     <= spec_d;
        spec_res_q <= spec_res_d;
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_div_unit_seq.sv
// Scoreboard bench: drives a fast-special and a full-latency divider in lockstep
// and checks both against an arithmetic reference model.
module tb_div_unit_seq;
    import div_unit_seq_pkg::*;

    typedef struct {
        logic [31:0] res;
        int          cycle;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [1:0]        op;
    logic [31:0]       dividend;
    logic [31:0]       divisor;
    logic [1:0]        busy_w;
    logic [1:0]        done_w;
    logic [1:0][31:0]  result_w;

    int          cyc = 0;
    int          free_cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    logic [31:0] hold [2];
    exp_t        q_exp [2][$];
    exp_t        mon_e;

    div_unit_seq #(.SPECIAL_FAST(1'b1)) dut_fast (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .dividend(dividend), .divisor(divisor),
        .busy(busy_w[0]), .done(done_w[0]), .result(result_w[0])
    );

    div_unit_seq #(.SPECIAL_FAST(1'b0)) dut_slow (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .dividend(dividend), .divisor(divisor),
        .busy(busy_w[1]), .done(done_w[1]), .result(result_w[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: RISC-V division semantics with wide integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, qq, rr;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (o[0] == 1'b0) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        qq = sa / sb;
        rr = sa % sb;
        return o[1] ? rr[31:0] : qq[31:0];
    endfunction

    function automatic int latency(input int inst, input logic [1:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
        bit special;
        special = (b == 32'd0) || (o[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (inst == 0 && special) ? 2 : 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issues one operation in the first cycle both dividers can accept it.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int n);
        exp_t e;
        wait_until(free_cyc);
        n        = cyc;
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        for (int i = 0; i < 2; i++) begin
            e.res   = ref_result(o, a, b);
            e.cycle = n + latency(i, o, a, b);
            q_exp[i].push_back(e);
        end
        free_cyc = n + 34;
        @(posedge clk);
        #1;
        start    = 1'b0;
        op       = 2'($urandom);
        dividend = $urandom;
        divisor  = $urandom;
        for (int i = 0; i < 2; i++) check($sformatf("busy_after_start[%0d]", i), busy_w[i], 1'b1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                if (done_w[i]) begin
                    if (q_exp[i].size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_done[%0d]: actual done=1 expected done=0 (cycle %0d)", i, cyc);
                    end else begin
                        mon_e = q_exp[i].pop_front();
                        check($sformatf("result[%0d]", i), result_w[i], mon_e.res);
                        check($sformatf("done_cycle[%0d]", i), cyc, mon_e.cycle);
                        check($sformatf("busy_in_done[%0d]", i), busy_w[i], 1'b0);
                    end
                    hold[i] = result_w[i];
                end else begin
                    check($sformatf("result_hold[%0d]", i), result_w[i], hold[i]);
                end
                if (rst) hold[i] = '0;
            end
        end
    end

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    initial begin
        int   n;
        vec_t dir [$];

        rst = 1'b1; start = 1'b0; op = '0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_busy[%0d]", i), busy_w[i], 1'b0);
            check($sformatf("reset_done[%0d]", i), done_w[i], 1'b0);
            check($sformatf("reset_result[%0d]", i), result_w[i], 32'd0);
            hold[i] = '0;
        end
        mon_en   = 1'b1;
        free_cyc = cyc;

        dir = '{
            '{OP_DIVU, 32'd100, 32'd7},
            '{OP_REMU, 32'd100, 32'd7},
            '{OP_DIV,  -32'd7, 32'd2},
            '{OP_REM,  -32'd7, 32'd2},
            '{OP_DIV,  32'd7, -32'd2},
            '{OP_REM,  32'd7, -32'd2},
            '{OP_DIV,  32'h8000_0000, 32'd1},
            '{OP_DIVU, 32'd5, 32'd0},
            '{OP_REM,  32'd5, 32'd0},
            '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF},
            '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF}
        };
        foreach (dir[k]) issue(dir[k].o, dir[k].a, dir[k].b, n);

        // A start pulse mid-operation must be ignored.
        issue(OP_DIVU, 32'd1000, 32'd9, n);
        wait_until(n + 10);
        start = 1'b1; op = OP_REMU; dividend = 32'd77; divisor = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;

        // Issued in the done cycle of the previous operation: back-to-back.
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10, n);

        // Reset mid-operation discards it; no done may follow.
        issue(OP_DIVU, 32'hDEAD_BEEF, 32'd3, n);
        wait_until(n + 12);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) q_exp[i].delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("abort_busy[%0d]", i), busy_w[i], 1'b0);
            check($sformatf("abort_done[%0d]", i), done_w[i], 1'b0);
            check($sformatf("abort_result[%0d]", i), result_w[i], 32'd0);
        end
        free_cyc = cyc + 3;
        issue(OP_DIVU, 32'd9, 32'd3, n);

        for (int k = 0; k < 40; k++) issue(2'($urandom), pick_operand(), pick_operand(), n);

        wait_until(free_cyc + 2);
        for (int i = 0; i < 2; i++) check($sformatf("pending_at_end[%0d]", i), q_exp[i].size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
